// File: rtl/scan_mux4.sv
// scan_mux4: 4-digit multiplexed 7-segment scanner with frame-synced load.
// Optional leading-zero blanking: define SCAN_MUX4_ZERO_BLANK_EN.
module scan_mux4 #(
  parameter int DIV = 50000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] valor,
  output logic [3:0]  digito,
  output logic        apagar,
  output logic [3:0]  anodo,
  output logic        quadro,
  output logic        pendente
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic [15:0]   r_disp;
  logic [15:0]   r_shadow;
  logic          r_pend;

  logic          w_tick;
  logic          w_frame;
  logic [3:0]    w_nib;
  logic [3:0]    w_an;
  logic          w_blank;

  assign w_tick  = (r_cnt == LAST);
  assign w_frame = w_tick & (r_sel == 2'd3);

  // prescaler: 0..DIV-1 then wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // digit index advances once per tick, 3 wraps to 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sel <= 2'd0;
    end else if (w_tick) begin
      r_sel <= r_sel + 2'd1;
    end
  end

  // shadow capture; newest load overwrites older ones
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (load) begin
      r_shadow <= valor;
    end
  end

  // pending flag: boundary consumes it, even if a load lands there
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= 1'b0;
    end else if (w_frame) begin
      r_pend <= 1'b0;
    end else if (load) begin
      r_pend <= 1'b1;
    end
  end

  // display register only changes on a frame boundary
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_disp <= '0;
    end else if (w_frame) begin
      if (load) begin
        r_disp <= valor;
      end else if (r_pend) begin
        r_disp <= r_shadow;
      end
    end
  end

  // digit nibble and active-low anode for current index
  always_comb begin
    w_nib = r_disp[3:0];
    w_an  = 4'b1110;
    unique case (r_sel)
      2'd0: begin
        w_nib = r_disp[3:0];
        w_an  = 4'b1110;
      end
      2'd1: begin
        w_nib = r_disp[7:4];
        w_an  = 4'b1101;
      end
      2'd2: begin
        w_nib = r_disp[11:8];
        w_an  = 4'b1011;
      end
      2'd3: begin
        w_nib = r_disp[15:12];
        w_an  = 4'b0111;
      end
    endcase
  end

`ifdef SCAN_MUX4_ZERO_BLANK_EN
  // blank digit k>0 when it and every higher nibble are zero
  always_comb begin
    w_blank = 1'b0;
    unique case (r_sel)
      2'd0: w_blank = 1'b0;
      2'd1: w_blank = (r_disp[15:4] == 12'h000);
      2'd2: w_blank = (r_disp[15:8] == 8'h00);
      2'd3: w_blank = (r_disp[15:12] == 4'h0);
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  assign digito   = w_nib;
  assign anodo    = w_an;
  assign apagar   = w_blank;
  assign quadro   = w_frame;
  assign pendente = r_pend;

endmodule

// File: tb/tb_scan_mux4.sv
// tb_scan_mux4: directed checks of scan_mux4 (DIV=4 and DIV=2 instances).
// Run with SCAN_MUX4_ZERO_BLANK_EN defined to exercise blanking.
module tb_scan_mux4;

`ifdef SCAN_MUX4_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst2_n;
  logic        load;
  logic [15:0] valor;
  logic [3:0]  digito, anodo;
  logic        apagar, quadro, pendente;
  logic [3:0]  digito2, anodo2;
  logic        apagar2, quadro2, pendente2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scan_mux4 #(.DIV(4)) u_dut (
    .clock(clk), .reset_n(rst_n), .load(load), .valor(valor),
    .digito(digito), .apagar(apagar), .anodo(anodo),
    .quadro(quadro), .pendente(pendente)
  );

  scan_mux4 #(.DIV(2)) u_div2 (
    .clock(clk), .reset_n(rst2_n), .load(1'b0), .valor(16'h0000),
    .digito(digito2), .apagar(apagar2), .anodo(anodo2),
    .quadro(quadro2), .pendente(pendente2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] one;
    logic [3:0] ea;
    one = 4'b0001;
    rst_n = 1'b0; rst2_n = 1'b0; load = 1'b0; valor = '0;
    step(2);
    n_cmp++;
    if (anodo !== 4'b1110) begin
      n_err++; $display("FAIL rst_anodo got %b exp 1110", anodo);
    end
    n_cmp++;
    if (digito !== 4'h0) begin
      n_err++; $display("FAIL rst_digito got %h exp 0", digito);
    end
    n_cmp++;
    if (quadro !== 1'b0 || pendente !== 1'b0) begin
      n_err++; $display("FAIL rst_q_p got %b%b exp 00", quadro, pendente);
    end
    n_cmp++;
    if (apagar !== 1'b0) begin
      n_err++; $display("FAIL rst_apagar got %b exp 0", apagar);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ea = ~(one << (k / 4));
      n_cmp++;
      if (anodo !== ea) begin
        n_err++; $display("FAIL scan_anodo k=%0d got %b exp %b", k, anodo, ea);
      end
      n_cmp++;
      if (quadro !== (k == 15)) begin
        n_err++; $display("FAIL scan_quadro k=%0d got %b exp %b", k, quadro, k == 15);
      end
      step(1);
    end
  endtask

  task automatic test_load_midframe;
    logic [15:0] v;
    logic [3:0]  en;
    v = 16'h1234;
    step(5);
    load = 1'b1; valor = v;
    step(1);
    load = 1'b0; valor = 16'hFFFF;
    n_cmp++;
    if (pendente !== 1'b1 || digito !== 4'h0) begin
      n_err++; $display("FAIL mid_pend got p=%b d=%h exp p=1 d=0", pendente, digito);
    end
    step(9);
    n_cmp++;
    if (quadro !== 1'b1 || pendente !== 1'b1 || digito !== 4'h0) begin
      n_err++;
      $display("FAIL mid_bnd got q=%b p=%b d=%h exp 1 1 0", quadro, pendente, digito);
    end
    step(1);
    for (int d = 0; d < 4; d++) begin
      en = v[4*d +: 4];
      n_cmp++;
      if (digito !== en || pendente !== 1'b0 || apagar !== 1'b0) begin
        n_err++;
        $display("FAIL mid_show d=%0d got %h p=%b a=%b exp %h 0 0", d, digito, pendente, apagar, en);
      end
      if (d < 3) step(4);
    end
  endtask

  task automatic test_boundary_load;
    logic [15:0] v;
    logic [3:0]  en;
    v = 16'hABCD;
    step(3);
    n_cmp++;
    if (quadro !== 1'b1) begin
      n_err++; $display("FAIL bnd_quadro got %b exp 1", quadro);
    end
    load = 1'b1; valor = v;
    step(1);
    load = 1'b0; valor = 16'h0000;
    for (int d = 0; d < 4; d++) begin
      en = v[4*d +: 4];
      n_cmp++;
      if (digito !== en || pendente !== 1'b0) begin
        n_err++;
        $display("FAIL bnd_show d=%0d got %h p=%b exp %h 0", d, digito, pendente, en);
      end
      step(4);
    end
  endtask

  task automatic test_reset_midframe;
    step(5);
    load = 1'b1; valor = 16'h00FF;
    step(1);
    load = 1'b0;
    n_cmp++;
    if (pendente !== 1'b1) begin
      n_err++; $display("FAIL rmf_pend got %b exp 1", pendente);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pendente !== 1'b0 || anodo !== 4'b1110 || digito !== 4'h0 || quadro !== 1'b0) begin
      n_err++;
      $display("FAIL rmf_async got p=%b a=%b d=%h q=%b exp 0 1110 0 0", pendente, anodo, digito, quadro);
    end
    step(1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (anodo !== 4'b1110) begin
        n_err++; $display("FAIL rmf_hold k=%0d got %b exp 1110", k, anodo);
      end
      step(1);
    end
    n_cmp++;
    if (anodo !== 4'b1101 || digito !== 4'h0) begin
      n_err++; $display("FAIL rmf_tick got a=%b d=%h exp 1101 0", anodo, digito);
    end
    step(12);
    n_cmp++;
    if (digito !== 4'h0 || pendente !== 1'b0) begin
      n_err++; $display("FAIL rmf_discard got d=%h p=%b exp 0 0", digito, pendente);
    end
  endtask

  task automatic test_blank;
    logic [15:0] v;
    logic [3:0]  en;
    logic        eb;
    v = 16'h0045;
    load = 1'b1; valor = v;
    step(1);
    load = 1'b0;
    step(15);
    for (int d = 0; d < 4; d++) begin
      en = v[4*d +: 4];
      eb = BLANK_EN && (d >= 2);
      n_cmp++;
      if (digito !== en || apagar !== eb) begin
        n_err++;
        $display("FAIL blank45 d=%0d got %h/%b exp %h/%b", d, digito, apagar, en, eb);
      end
      if (d < 3) step(4);
    end
    load = 1'b1; valor = 16'h0000;
    step(1);
    load = 1'b0;
    step(3);
    for (int d = 0; d < 4; d++) begin
      eb = BLANK_EN && (d >= 1);
      n_cmp++;
      if (digito !== 4'h0 || apagar !== eb) begin
        n_err++;
        $display("FAIL blank00 d=%0d got %h/%b exp 0/%b", d, digito, apagar, eb);
      end
      step(4);
    end
  endtask

  task automatic test_div2;
    logic [3:0] one;
    logic [3:0] ea;
    logic       eq;
    one = 4'b0001;
    rst2_n = 1'b0;
    step(1);
    rst2_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      eq = (c == 8) || (c == 16);
      ea = ~(one << (((c - 1) / 2) % 4));
      n_cmp++;
      if (quadro2 !== eq) begin
        n_err++; $display("FAIL div2_quadro c=%0d got %b exp %b", c, quadro2, eq);
      end
      n_cmp++;
      if (anodo2 !== ea) begin
        n_err++; $display("FAIL div2_anodo c=%0d got %b exp %b", c, anodo2, ea);
      end
      step(1);
    end
  endtask

  initial begin
    test_reset();
    test_load_midframe();
    test_boundary_load();
    test_reset_midframe();
    test_blank();
    test_div2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
